// File: rtl/nrf_spi_pkg.sv
// nRF24L01 SPI command opcodes, engine state encoding and payload limit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package nrf_spi_pkg;

    localparam logic [7:0] OP_R_REGISTER   = 8'h00;
    localparam logic [7:0] OP_W_REGISTER   = 8'h20;
    localparam logic [7:0] OP_R_RX_PAYLOAD = 8'h61;
    localparam logic [7:0] OP_W_TX_PAYLOAD = 8'hA0;
    localparam logic [7:0] OP_FLUSH_TX     = 8'hE1;
    localparam logic [7:0] OP_FLUSH_RX     = 8'hE2;
    localparam logic [7:0] OP_NOP          = 8'hFF;

    // Largest radio payload; a transaction is this plus the command byte.
    localparam int MAX_PAYLOAD = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_FINISH,
        ST_GAP
    } spi_state_t;

endpackage

// File: rtl/nrf_spi_half_tick.sv
// SCK half-period timer: counts 0..HALF_DIV-1 while enabled, tick on the last count.
// Latency: first tick HALF_DIV cycles after enable rises from a cleared count.
// Backpressure: none; clear has priority over enable.
module nrf_spi_half_tick #(
    parameter int HALF_DIV = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Half-period counter, wraps to zero on every tick.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nrf_spi_master.sv
// SPI mode-0 master for the nRF24L01: multi-byte CSN-framed transactions, MSB first.
// Latency: 16*HALF_DIV cycles per byte after load, plus HALF_DIV CSN hold and CSN_GAP recovery.
// Backpressure: tx_ready only in LOAD; a missing tx_valid stalls with SCK low and CSN held.
module nrf_spi_master
    import nrf_spi_pkg::*;
#(
    parameter int HALF_DIV = 3,
    parameter int LEN_W    = 6,
    parameter int CSN_GAP  = 3
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             spi_csn,
    output logic             spi_sck,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int GW = (CSN_GAP > 1) ? $clog2(CSN_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(CSN_GAP - 1);

    spi_state_t       state, state_nxt;
    logic [LEN_W-1:0] byte_cnt;
    logic [2:0]       bit_cnt;
    logic             phase;      // 0: SCK low half, 1: SCK high half
    logic [7:0]       tx_sh;
    logic [7:0]       rx_sh;
    logic [GW-1:0]    gap_cnt;
    logic             tick;
    logic             ht_en;
    logic             byte_end;
    logic             gap_end;

    assign ht_en    = (state == ST_SHIFT) || (state == ST_FINISH);
    assign byte_end = (state == ST_SHIFT) && tick && phase && (bit_cnt == 3'd7);
    assign gap_end  = (state == ST_GAP) && (gap_cnt == GAP_LAST);

    nrf_spi_half_tick #(.HALF_DIV(HALF_DIV)) u_half_tick (
        .clk   (clk_50),
        .rst_n (rst_n),
        .clr   (!ht_en),
        .en    (ht_en),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk_50) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode plus the state-derived handshake/status outputs.
    always_comb begin
        state_nxt = state;
        tx_ready  = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start && (len != '0)) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                tx_ready = 1'b1;
                if (tx_valid) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (byte_end) state_nxt = (byte_cnt == LEN_W'(1)) ? ST_FINISH : ST_LOAD;
            end
            ST_FINISH: begin
                if (tick) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (gap_end) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift datapath, pin drivers, byte/bit/gap counters and completion pulses.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            bit_cnt  <= '0;
            phase    <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            gap_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            spi_csn  <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        byte_cnt <= len;
                        done     <= (len == '0);
                    end
                end
                ST_LOAD: begin
                    if (tx_valid) begin
                        tx_sh    <= tx_data;
                        spi_mosi <= tx_data[7];
                        spi_csn  <= 1'b0;
                        bit_cnt  <= '0;
                        phase    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (tick && !phase) begin
                        // Rising edge: slave data has been stable for a full low half.
                        spi_sck <= 1'b1;
                        rx_sh   <= {rx_sh[6:0], spi_miso};
                        phase   <= 1'b1;
                    end else if (tick) begin
                        spi_sck <= 1'b0;
                        phase   <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= rx_sh;
                            rx_valid <= 1'b1;
                            byte_cnt <= byte_cnt - 1'b1;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            tx_sh    <= {tx_sh[6:0], 1'b0};
                            spi_mosi <= tx_sh[6];
                        end
                    end
                end
                ST_FINISH: begin
                    if (tick) begin
                        spi_csn <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
